gbf_bus_scheduler: RTL and testbench
====================================

GBF_BUS_SCHEDULER -- requirements
Module: gbf_bus_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter HEIGHT, default 32, GBF depth in words; AW = $clog2(HEIGHT).
REQ-003 SHALL have parameter NUM_PORTS, default 4, GBF read ports served.
REQ-004 SHALL have parameter NUM_REQ, default 4, requesters per port; RW = $clog2(NUM_REQ), minimum 1.
REQ-005 SHALL have parameter IDX_W, default 8, width of row/column indices.
REQ-006 SHALL have parameter RAM_LAT, default 1, GBF read latency in cycles (1..4).
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port req, input, NUM_PORTS*NUM_REQ; bit p*NUM_REQ+r is requester r of port p.
REQ-010 SHALL have port req_row, input, NUM_PORTS*NUM_REQ*IDX_W; row index per requester, same packing.
REQ-011 SHALL have port req_col, input, NUM_PORTS*NUM_REQ*IDX_W; column index per requester.
REQ-012 SHALL have port base_addr, input, AW; GBF base address of the matrix.
REQ-013 SHALL have port row_stride, input, AW; words per matrix row.
REQ-014 SHALL have port ram_en, output, NUM_PORTS; read enable per GBF port.
REQ-015 SHALL have port ram_addr, output, NUM_PORTS*AW; read address per GBF port.
REQ-016 SHALL have port ram_q, input, NUM_PORTS*WIDTH; GBF read data, valid RAM_LAT cycles after ram_en.
REQ-017 SHALL have port grant, output, NUM_PORTS*NUM_REQ; one-cycle pulse, at most one bit per port.
REQ-018 SHALL have port data_out, output, NUM_PORTS*WIDTH; data for the granted requester.
REQ-019 SHALL have port data_valid, output, NUM_PORTS; high with the grant pulse.
REQ-020 SHALL have port addr_err, output, NUM_PORTS; one-cycle pulse with grant for an out-of-range access.
REQ-021 SHALL have port busy, output, 1; high while any access is in flight.

Function
REQ-022 SHALL treat each port independently: own arbiter, pointer, mask and pipeline.
REQ-023 SHALL arbitrate each cycle among eligible requesters (req high, not masked) round-robin, starting from rr_ptr.
REQ-024 SHALL, on a win by r in cycle N, register ram_en=1 and ram_addr for cycle N+1, set rr_ptr=(r+1) mod NUM_REQ, and set mask[r].
REQ-025 SHALL compute address = base_addr + row*row_stride + col at full precision; if >= HEIGHT, ram_en stays 0 and the access is flagged as error.
REQ-026 SHALL carry winner id and error flag through a (1+RAM_LAT)-stage shift pipeline.
REQ-027 SHALL, in cycle N+1+RAM_LAT, pulse grant[r] and data_valid, with data_out=ram_q (0 and addr_err=1 if flagged), and clear mask[r].
REQ-028 SHALL exclude masked requesters; a requester is eligible again in the cycle after its grant.
REQ-029 SHALL sustain one issue per port per cycle when different requesters compete.
REQ-030 SHALL hold ram_en=0 and rr_ptr unchanged when no requester is eligible.
REQ-031 SHALL ignore req falling while masked; the in-flight access still completes and grants.
REQ-032 SHALL drive busy = OR of all pipeline valid bits across ports.

Reset
REQ-033 SHALL on rst clear ram_en, ram_addr, grant, data_valid, data_out, addr_err, busy, all masks and pipelines, and set rr_ptr=0.
REQ-034 SHALL abort in-flight accesses on rst: no grant issued for them afterwards.

Verification
REQ-035 Single: base=0, stride=4, port0 r2 row=1 col=3, RAM_LAT=1 -> ram_addr=7 in N+1, grant bit2 and data_valid in N+2, data_out=mem[7].
REQ-036 Contention: port0 r0..r3 all high and held, rr_ptr=0 -> wins r0,r1,r2,r3 in consecutive cycles, then r0 again.
REQ-037 Error: HEIGHT=32, base=30, stride=4, row=1, col=0 -> ram_en stays 0, grant with data_valid=1, addr_err=1, data_out=0.
REQ-038 Mask: r1 holds req through its grant -> no second issue for r1 before its grant; re-issue in the cycle after.
REQ-039 Reset mid-flight: rst in N+1 after an issue in N -> no grant in N+2, all outputs 0, next win from r0.
REQ-040 Parallel: ports 0..3 each request in the same cycle -> four grants in the same cycle, each with its own port's data.

Source files
------------

// File: rtl/gbf_bus_scheduler.sv
// Multi-port global-buffer read scheduler: per-port round-robin arbitration over
// requesters, address generation with range check, and a latency-matched grant pipeline.
module gbf_bus_scheduler #(
    parameter int WIDTH     = 32,
    parameter int HEIGHT    = 32,
    parameter int NUM_PORTS = 4,
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 8,
    parameter int RAM_LAT   = 1,
    localparam int AW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int RW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS*NUM_REQ-1:0]       req,
    input  logic [NUM_PORTS*NUM_REQ*IDX_W-1:0] req_row,
    input  logic [NUM_PORTS*NUM_REQ*IDX_W-1:0] req_col,
    input  logic [AW-1:0]                      base_addr,
    input  logic [AW-1:0]                      row_stride,
    output logic [NUM_PORTS-1:0]               ram_en,
    output logic [NUM_PORTS*AW-1:0]            ram_addr,
    input  logic [NUM_PORTS*WIDTH-1:0]         ram_q,
    output logic [NUM_PORTS*NUM_REQ-1:0]       grant,
    output logic [NUM_PORTS*WIDTH-1:0]         data_out,
    output logic [NUM_PORTS-1:0]               data_valid,
    output logic [NUM_PORTS-1:0]               addr_err,
    output logic                               busy
);

    localparam int STAGES = 1 + RAM_LAT;
    // Wide enough that base + row*stride + col can never wrap.
    localparam int FW     = AW + IDX_W + 2;

    function automatic logic [FW-1:0] calc_addr(input logic [AW-1:0]    base,
                                                input logic [AW-1:0]    stride,
                                                input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
        calc_addr = FW'(base) + FW'(row) * FW'(stride) + FW'(col);
    endfunction

    logic [NUM_PORTS-1:0] busy_vec;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [NUM_REQ-1:0] mask;
        logic [NUM_REQ-1:0] elig;
        logic [NUM_REQ-1:0] win_vec;
        logic [NUM_REQ-1:0] grant_vec;
        logic [RW-1:0]      rr_ptr;
        logic [RW-1:0]      win_id;
        logic               win;
        logic [IDX_W-1:0]   row_sel;
        logic [IDX_W-1:0]   col_sel;
        logic [FW-1:0]      addr_full;
        logic               addr_bad;
        logic               ram_en_p0;
        logic [AW-1:0]      ram_addr_p0;
        logic [STAGES-1:0]  vld_pipe;
        logic [STAGES-1:0]  err_pipe;
        logic [RW-1:0]      id_pipe [STAGES];
        logic               vld_last;
        logic               err_last;
        logic [RW-1:0]      id_last;

        assign elig = req[p*NUM_REQ +: NUM_REQ] & ~mask;

        // Scan downward so the requester closest to rr_ptr is the last one written.
        always_comb begin
            win     = 1'b0;
            win_id  = '0;
            row_sel = '0;
            col_sel = '0;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                int idx;
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (elig[idx]) begin
                    win     = 1'b1;
                    win_id  = RW'(idx);
                    row_sel = req_row[(p*NUM_REQ + idx)*IDX_W +: IDX_W];
                    col_sel = req_col[(p*NUM_REQ + idx)*IDX_W +: IDX_W];
                end
            end
        end

        assign addr_full = calc_addr(base_addr, row_stride, row_sel, col_sel);
        assign addr_bad  = (addr_full >= FW'(HEIGHT));

        assign vld_last = vld_pipe[STAGES-1];
        assign err_last = err_pipe[STAGES-1];
        assign id_last  = id_pipe[STAGES-1];

        always_comb begin
            win_vec   = '0;
            grant_vec = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                win_vec[r]   = win && (win_id == RW'(r));
                grant_vec[r] = vld_last && (id_last == RW'(r));
            end
        end

        // Issue stage (p0) feeding the RAM, then the id/error shift pipeline.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr      <= '0;
                mask        <= '0;
                ram_en_p0   <= 1'b0;
                ram_addr_p0 <= '0;
                vld_pipe    <= '0;
                err_pipe    <= '0;
                for (int s = 0; s < STAGES; s++) id_pipe[s] <= '0;
            end else begin
                ram_en_p0 <= win && !addr_bad;
                if (win && !addr_bad) ram_addr_p0 <= addr_full[AW-1:0];
                if (win) rr_ptr <= (win_id == RW'(NUM_REQ - 1)) ? '0 : win_id + RW'(1);
                mask     <= (mask & ~grant_vec) | win_vec;
                vld_pipe <= {vld_pipe[STAGES-2:0], win};
                err_pipe <= {err_pipe[STAGES-2:0], win && addr_bad};
                id_pipe[0] <= win_id;
                for (int s = 1; s < STAGES; s++) id_pipe[s] <= id_pipe[s-1];
            end
        end

        // Completion stage: read data lines up with the last pipeline slot.
        assign ram_en[p]                       = ram_en_p0;
        assign ram_addr[p*AW +: AW]            = ram_addr_p0;
        assign grant[p*NUM_REQ +: NUM_REQ]     = grant_vec;
        assign data_valid[p]                   = vld_last;
        assign addr_err[p]                     = vld_last && err_last;
        assign data_out[p*WIDTH +: WIDTH]      = (vld_last && !err_last) ?
                                                 ram_q[p*WIDTH +: WIDTH] : '0;
        assign busy_vec[p]                     = |vld_pipe;
    end

    assign busy = |busy_vec;

endmodule

// File: tb/tb_gbf_bus_scheduler.sv
// Directed bench for gbf_bus_scheduler with a one-cycle-latency GBF model per port.
module tb_gbf_bus_scheduler;

    localparam int WIDTH = 32;
    localparam int HEIGHT = 32;
    localparam int NP = 4;
    localparam int NR = 4;
    localparam int IW = 8;
    localparam int AW = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NP*NR-1:0]      req = '0;
    logic [NP*NR*IW-1:0]   req_row = '0;
    logic [NP*NR*IW-1:0]   req_col = '0;
    logic [AW-1:0]         base_addr = '0;
    logic [AW-1:0]         row_stride = '0;
    logic [NP-1:0]         ram_en;
    logic [NP*AW-1:0]      ram_addr;
    logic [NP*WIDTH-1:0]   ram_q = '0;
    logic [NP*NR-1:0]      grant;
    logic [NP*WIDTH-1:0]   data_out;
    logic [NP-1:0]         data_valid;
    logic [NP-1:0]         addr_err;
    logic                  busy;

    int passed = 0;
    int total = 0;

    gbf_bus_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_PORTS(NP), .NUM_REQ(NR),
                        .IDX_W(IW), .RAM_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_row(req_row), .req_col(req_col),
        .base_addr(base_addr), .row_stride(row_stride), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_q(ram_q), .grant(grant), .data_out(data_out),
        .data_valid(data_valid), .addr_err(addr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input int p, input int a);
        mem_val = 32'hA500_0000 | (p << 8) | a;
    endfunction

    always @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (ram_en[p]) ram_q[p*WIDTH +: WIDTH] <= mem_val(p, int'(ram_addr[p*AW +: AW]));
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input int r, input int row, input int col);
        req[p*NR + r] = 1'b1;
        req_row[(p*NR + r)*IW +: IW] = IW'(row);
        req_col[(p*NR + r)*IW +: IW] = IW'(col);
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (ram_en !== 4'h0) $display("FAIL reset_ram_en got %h exp 0", ram_en); else passed++;
        total++; if (ram_addr !== '0) $display("FAIL reset_ram_addr got %h exp 0", ram_addr); else passed++;
        total++; if (grant !== '0) $display("FAIL reset_grant got %h exp 0", grant); else passed++;
        total++; if (data_valid !== 4'h0) $display("FAIL reset_data_valid got %h exp 0", data_valid); else passed++;
        total++; if (data_out !== '0) $display("FAIL reset_data_out got %h exp 0", data_out); else passed++;
        total++; if (addr_err !== 4'h0) $display("FAIL reset_addr_err got %h exp 0", addr_err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        base_addr = 5'd0;
        row_stride = 5'd4;
        set_req(0, 2, 1, 3);
        tick();
        req = '0;
        total++; if (ram_en !== 4'h1) $display("FAIL single_ram_en got %h exp 1", ram_en); else passed++;
        total++; if (ram_addr[4:0] !== 5'd7) $display("FAIL single_ram_addr got %0d exp 7", ram_addr[4:0]); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else passed++;
        total++; if (grant !== '0) $display("FAIL single_early_grant got %h exp 0", grant); else passed++;
        tick();
        total++; if (grant !== 16'h0004) $display("FAIL single_grant got %h exp 0004", grant); else passed++;
        total++; if (data_valid !== 4'h1) $display("FAIL single_valid got %h exp 1", data_valid); else passed++;
        total++; if (data_out[31:0] !== mem_val(0, 7))
            $display("FAIL single_data got %h exp %h", data_out[31:0], mem_val(0, 7)); else passed++;
        total++; if (addr_err !== 4'h0) $display("FAIL single_addr_err got %h exp 0", addr_err); else passed++;
        tick();
        total++; if (grant !== '0 || busy !== 1'b0)
            $display("FAIL single_idle got grant=%h busy=%b exp 0/0", grant, busy); else passed++;
    endtask

    task automatic test_contention();
        int exp_addr [5] = '{0, 4, 8, 12, 0};
        logic [15:0] exp_g;
        do_reset();
        base_addr = 5'd0;
        row_stride = 5'd4;
        for (int r = 0; r < NR; r++) set_req(0, r, r, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) req = '0;
            total++; if (ram_en[0] !== 1'b1 || ram_addr[4:0] !== 5'(exp_addr[k-1]))
                $display("FAIL contend_issue%0d got en=%b addr=%0d exp en=1 addr=%0d",
                         k, ram_en[0], ram_addr[4:0], exp_addr[k-1]); else passed++;
            exp_g = (k >= 2) ? (16'h1 << (k - 2)) : 16'h0;
            total++; if (grant !== exp_g)
                $display("FAIL contend_grant%0d got %h exp %h", k, grant, exp_g); else passed++;
            if (k >= 2) begin
                total++; if (data_out[31:0] !== mem_val(0, exp_addr[k-2]))
                    $display("FAIL contend_data%0d got %h exp %h", k, data_out[31:0],
                             mem_val(0, exp_addr[k-2])); else passed++;
            end
        end
        tick();
        total++; if (grant !== 16'h0001 || data_out[31:0] !== mem_val(0, 0))
            $display("FAIL contend_last got grant=%h data=%h exp 0001/%h", grant, data_out[31:0],
                     mem_val(0, 0)); else passed++;
        total++; if (ram_en !== 4'h0) $display("FAIL contend_drain_en got %h exp 0", ram_en); else passed++;
    endtask

    task automatic test_error();
        do_reset();
        base_addr = 5'd30;
        row_stride = 5'd4;
        set_req(0, 0, 1, 0);
        tick();
        req = '0;
        total++; if (ram_en !== 4'h0) $display("FAIL err_ram_en got %h exp 0", ram_en); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL err_busy got %b exp 1", busy); else passed++;
        tick();
        total++; if (grant !== 16'h0001) $display("FAIL err_grant got %h exp 0001", grant); else passed++;
        total++; if (data_valid !== 4'h1) $display("FAIL err_valid got %h exp 1", data_valid); else passed++;
        total++; if (addr_err !== 4'h1) $display("FAIL err_flag got %h exp 1", addr_err); else passed++;
        total++; if (data_out[31:0] !== 32'h0) $display("FAIL err_data got %h exp 0", data_out[31:0]); else passed++;
        tick();
        total++; if (addr_err !== 4'h0) $display("FAIL err_pulse got %h exp 0", addr_err); else passed++;
    endtask

    task automatic test_mask();
        do_reset();
        base_addr = 5'd0;
        row_stride = 5'd4;
        set_req(0, 1, 0, 5);
        tick();
        total++; if (ram_en[0] !== 1'b1 || ram_addr[4:0] !== 5'd5)
            $display("FAIL mask_first got en=%b addr=%0d exp 1/5", ram_en[0], ram_addr[4:0]); else passed++;
        tick();
        total++; if (ram_en[0] !== 1'b0) $display("FAIL mask_blocked got %b exp 0", ram_en[0]); else passed++;
        total++; if (grant !== 16'h0002) $display("FAIL mask_grant got %h exp 0002", grant); else passed++;
        tick();
        total++; if (ram_en[0] !== 1'b0) $display("FAIL mask_gap got %b exp 0", ram_en[0]); else passed++;
        tick();
        req = '0;
        total++; if (ram_en[0] !== 1'b1 || ram_addr[4:0] !== 5'd5)
            $display("FAIL mask_reissue got en=%b addr=%0d exp 1/5", ram_en[0], ram_addr[4:0]); else passed++;
        tick();
        total++; if (grant !== 16'h0002 || data_out[31:0] !== mem_val(0, 5))
            $display("FAIL mask_regrant got grant=%h data=%h exp 0002/%h", grant, data_out[31:0],
                     mem_val(0, 5)); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        base_addr = 5'd0;
        row_stride = 5'd4;
        set_req(0, 2, 1, 2);
        tick();
        req = '0;
        rst = 1'b1;
        total++; if (ram_en[0] !== 1'b1) $display("FAIL midrst_issue got %b exp 1", ram_en[0]); else passed++;
        tick();
        rst = 1'b0;
        total++; if (grant !== '0 || data_valid !== 4'h0)
            $display("FAIL midrst_grant got grant=%h valid=%h exp 0/0", grant, data_valid); else passed++;
        total++; if (ram_en !== 4'h0 || busy !== 1'b0 || addr_err !== 4'h0 || data_out !== '0)
            $display("FAIL midrst_outputs got en=%h busy=%b err=%h exp all 0", ram_en, busy, addr_err);
        else passed++;
        set_req(0, 0, 0, 1);
        set_req(0, 1, 0, 2);
        set_req(0, 2, 1, 2);
        set_req(0, 3, 0, 3);
        tick();
        req = '0;
        total++; if (ram_en[0] !== 1'b1 || ram_addr[4:0] !== 5'd1)
            $display("FAIL midrst_next_r0 got en=%b addr=%0d exp 1/1", ram_en[0], ram_addr[4:0]); else passed++;
        tick();
        total++; if (grant !== 16'h0001) $display("FAIL midrst_next_grant got %h exp 0001", grant); else passed++;
        tick();
    endtask

    task automatic test_parallel();
        do_reset();
        base_addr = 5'd0;
        row_stride = 5'd4;
        for (int p = 0; p < NP; p++) set_req(p, p, 2, p + 2);
        tick();
        req = '0;
        total++; if (ram_en !== 4'hF) $display("FAIL par_ram_en got %h exp F", ram_en); else passed++;
        tick();
        total++; if (grant !== 16'h8421) $display("FAIL par_grant got %h exp 8421", grant); else passed++;
        total++; if (data_valid !== 4'hF) $display("FAIL par_valid got %h exp F", data_valid); else passed++;
        for (int p = 0; p < NP; p++) begin
            total++; if (data_out[p*WIDTH +: WIDTH] !== mem_val(p, 10 + p))
                $display("FAIL par_data%0d got %h exp %h", p, data_out[p*WIDTH +: WIDTH],
                         mem_val(p, 10 + p)); else passed++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_error();
        test_mask();
        test_reset_mid();
        test_parallel();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
